// File: rtl/serial_ctrl_master.sv
`default_nettype none
// ============================================================================
// serial_ctrl_master : host sequencer turning RESET/WRITE/READ requests into
//                      bit-serial frames for a serial_ctrl single-wire link.
// Revision: 1.0
// ============================================================================
module serial_ctrl_master #(
    parameter int                  CMD_LEN       = 2,
    parameter int                  DATA_LEN      = 8,
    parameter int                  GAP_CYCLES    = 3,
    parameter int                  RCV_SETUP     = 1,
    parameter int                  TURN_CYCLES   = 2,
    parameter logic [CMD_LEN-1:0]  RESET_CMD     = CMD_LEN'(0),
    parameter logic [CMD_LEN-1:0]  START_RCV_CMD = CMD_LEN'(1),
    parameter logic [CMD_LEN-1:0]  START_SND_CMD = CMD_LEN'(2),
    parameter logic [CMD_LEN-1:0]  UPDATE_CMD    = CMD_LEN'(3)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [DATA_LEN-1:0]  req_wdata,
    output logic                 resp_valid,
    output logic [DATA_LEN-1:0]  resp_rdata,
    output logic                 resp_err,
    output logic                 sd_out,
    output logic                 sd_oe,
    input  logic                 sd_in
);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int MAX_A   = (CMD_LEN > DATA_LEN) ? CMD_LEN : DATA_LEN;
    localparam int MAX_B   = (GAP_CYCLES > RCV_SETUP) ? GAP_CYCLES : RCV_SETUP;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > TURN_CYCLES) ? MAX_C : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_CMD   = 4'd2,
        S_STOP  = 4'd3,
        S_GAP   = 4'd4,
        S_SETUP = 4'd5,
        S_DTX   = 4'd6,
        S_DSTOP = 4'd7,
        S_TURN  = 4'd8,
        S_DRX   = 4'd9,
        S_REL   = 4'd10,
        S_RESP  = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [1:0]           op_q, op_d;
    logic [CMD_LEN-1:0]   cmd_q, cmd_d;
    logic [DATA_LEN-1:0]  shreg_q, shreg_d;
    logic [DATA_LEN-1:0]  rdata_q, rdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic                 sd_out_q, sd_out_d;
    logic                 sd_oe_q, sd_oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        op_d    = op_q;
        cmd_d   = cmd_q;
        shreg_d = shreg_q;
        rdata_d = rdata_q;

        case (state_q)
            // RESP doubles as an accept slot so back-to-back requests lose no cycle
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (req_valid) begin
                    op_d    = req_op;
                    phase_d = 1'b0;
                    shreg_d = req_wdata;
                    state_d = S_START;
                    case (req_op)
                        OP_RESET: cmd_d   = RESET_CMD;
                        OP_WRITE: cmd_d   = START_RCV_CMD;
                        OP_READ:  cmd_d   = START_SND_CMD;
                        default:  state_d = S_RESP;
                    endcase
                end
            end
            S_START: begin
                state_d = S_CMD;
                cnt_d   = CNT_W'(CMD_LEN - 1);
            end
            S_CMD: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    cmd_d = cmd_q << 1;
                end
            end
            S_STOP: begin
                state_d = S_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
                if (op_q == OP_WRITE && !phase_q) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(RCV_SETUP - 1);
                end else if (op_q == OP_READ) begin
                    state_d = S_TURN;
                    cnt_d   = CNT_W'(TURN_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == OP_WRITE && !phase_q) begin
                    // data has been shifted in; commit it with UPDATE
                    state_d = S_START;
                    cmd_d   = UPDATE_CMD;
                    phase_d = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_DTX;
                    cnt_d   = CNT_W'(DATA_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DTX: begin
                if (cnt_q == '0) begin
                    state_d = S_DSTOP;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    shreg_d = shreg_q << 1;
                end
            end
            S_DSTOP: begin
                state_d = S_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    state_d = S_DRX;
                    cnt_d   = CNT_W'(DATA_LEN - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRX: begin
                shreg_d = {shreg_q[DATA_LEN-2:0], sd_in};
                if (cnt_q == '0) begin
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REL: begin
                state_d = S_RESP;
                rdata_d = shreg_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the pins come straight off flops
        req_ready_d  = (state_d == S_IDLE) || (state_d == S_RESP);
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = (state_d == S_RESP) && (op_d == 2'b11);
        sd_oe_d      = !((state_d == S_TURN) || (state_d == S_DRX) || (state_d == S_REL));
        sd_out_d     = 1'b0;
        case (state_d)
            S_START: sd_out_d = 1'b1;
            S_CMD:   sd_out_d = cmd_d[CMD_LEN-1];
            S_DTX:   sd_out_d = shreg_d[DATA_LEN-1];
            default: sd_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            op_q         <= 2'b00;
            cmd_q        <= '0;
            shreg_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            sd_out_q     <= 1'b0;
            sd_oe_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            op_q         <= op_d;
            cmd_q        <= cmd_d;
            shreg_q      <= shreg_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            sd_out_q     <= sd_out_d;
            sd_oe_q      <= sd_oe_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    assign sd_out     = sd_out_q;
    assign sd_oe      = sd_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_ctrl_master.sv
`default_nettype none
// ============================================================================
// tb_serial_ctrl_master : scoreboard bench with a behavioural serial_ctrl slave.
// Revision: 1.0
// ============================================================================
module tb_serial_ctrl_master;

    localparam int         CMD_LEN   = 2;
    localparam int         DL        = 8;
    localparam int         GAP       = 3;
    localparam int         RCV_SETUP = 1;
    localparam int         TURN      = 2;
    localparam logic [1:0] RESET_CMD = 2'b00;
    localparam logic [1:0] SRCV_CMD  = 2'b01;
    localparam logic [1:0] SSND_CMD  = 2'b10;
    localparam logic [1:0] UPD_CMD   = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [DL-1:0] req_wdata;
    logic          resp_valid, resp_err;
    logic [DL-1:0] resp_rdata;
    logic          sd_out, sd_oe, sd_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_ctrl_master #(
        .CMD_LEN(CMD_LEN), .DATA_LEN(DL), .GAP_CYCLES(GAP), .RCV_SETUP(RCV_SETUP),
        .TURN_CYCLES(TURN), .RESET_CMD(RESET_CMD), .START_RCV_CMD(SRCV_CMD),
        .START_SND_CMD(SSND_CMD), .UPDATE_CMD(UPD_CMD)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .sd_out(sd_out),
        .sd_oe(sd_oe), .sd_in(sd_in)
    );

    // Behavioural serial_ctrl slave on the shared pad (weak pull-down when undriven)
    localparam int M_IDLE = 0, M_CMD = 1, M_STOP = 2, M_SETUP = 3, M_RX = 4, M_TURN = 5, M_TX = 6;
    int            m_st, m_cnt;
    logic [1:0]    m_cmd;
    logic [DL-1:0] m_rx, m_tx, m_bit_out;
    logic          m_reset, s_oe, s_out;

    assign sd_in = s_oe ? s_out : (sd_oe ? sd_out : 1'b0);

    always @(posedge clk) begin
        if (rst) begin
            m_st <= M_IDLE; m_cnt <= 0; m_cmd <= 2'b00; m_rx <= '0; m_tx <= '0;
            m_bit_out <= '0; m_reset <= 1'b0; s_oe <= 1'b0; s_out <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (sd_oe && sd_out) begin m_st <= M_CMD; m_cnt <= 0; end
                M_CMD: begin
                    m_cmd <= {m_cmd[CMD_LEN-2:0], sd_out};
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == CMD_LEN - 1) m_st <= M_STOP;
                end
                M_STOP: begin
                    m_st    <= M_IDLE;
                    m_cnt   <= 0;
                    m_reset <= (m_cmd == RESET_CMD);
                    case (m_cmd)
                        SRCV_CMD: m_st <= M_SETUP;
                        SSND_CMD: begin m_st <= M_TURN; m_tx <= m_bit_out; end
                        UPD_CMD:  m_bit_out <= m_rx;
                        default:  ;
                    endcase
                end
                M_SETUP: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == RCV_SETUP - 1) begin m_st <= M_RX; m_cnt <= 0; end
                end
                M_RX: begin
                    m_rx  <= {m_rx[DL-2:0], sd_out};
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == DL - 1) m_st <= M_IDLE;
                end
                M_TURN: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == TURN - 1) begin
                        m_st <= M_TX; m_cnt <= 0; s_oe <= 1'b1;
                        s_out <= m_tx[DL-1]; m_tx <= m_tx << 1;
                    end
                end
                M_TX: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == DL - 1) begin
                        s_oe <= 1'b0; s_out <= 1'b0; m_st <= M_IDLE;
                    end else begin
                        s_out <= m_tx[DL-1]; m_tx <= m_tx << 1;
                    end
                end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // Expected per-cycle vector: {req_ready, resp_valid, resp_err, sd_oe, sd_out, pad_clash}
    typedef struct packed {
        logic [5:0]    v;
        logic          chk;
        logic [DL-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    task automatic push_e(input logic [5:0] v, input logic chk, input logic [DL-1:0] rd);
        exp_t e;
        e.v = v; e.chk = chk; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic push_line(input int n, input logic oe);
        for (int i = 0; i < n; i++) push_e({3'b000, oe, 2'b00}, 1'b0, '0);
    endtask

    task automatic push_frame(input logic [CMD_LEN-1:0] c);
        logic [CMD_LEN-1:0] t;
        t = c;
        push_e(6'b000110, 1'b0, '0);
        for (int i = 0; i < CMD_LEN; i++) begin
            push_e({4'b0001, t[CMD_LEN-1], 1'b0}, 1'b0, '0);
            t = t << 1;
        end
        push_e(6'b000100, 1'b0, '0);
    endtask

    task automatic push_resp(input logic err, input logic chk, input logic [DL-1:0] rd);
        push_e({2'b11, err, 3'b100}, chk, rd);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_e(6'b100100, 1'b0, '0);
    endtask

    task automatic push_txn(input logic [1:0] op, input logic [DL-1:0] wd, input logic [DL-1:0] rd);
        logic [DL-1:0] t;
        t = wd;
        case (op)
            2'b00: begin push_frame(RESET_CMD); push_line(GAP, 1'b1); push_resp(1'b0, 1'b0, '0); end
            2'b01: begin
                push_frame(SRCV_CMD);
                push_line(RCV_SETUP, 1'b1);
                for (int i = 0; i < DL; i++) begin
                    push_e({4'b0001, t[DL-1], 1'b0}, 1'b0, '0);
                    t = t << 1;
                end
                push_line(1 + GAP, 1'b1);
                push_frame(UPD_CMD);
                push_line(GAP, 1'b1);
                push_resp(1'b0, 1'b0, '0);
            end
            2'b10: begin push_frame(SSND_CMD); push_line(TURN + DL + 1, 1'b0); push_resp(1'b0, 1'b1, rd); end
            default: push_resp(1'b1, 1'b0, '0);
        endcase
    endtask

    task automatic issue(input logic [1:0] op, input logic [DL-1:0] wd);
        req_valid = 1'b1; req_op = op; req_wdata = wd;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [5:0] obs;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, sd_oe, sd_out} !== 5'b10010) begin
            failures++; $display("FAIL reset_state: got %b want 10010", {req_ready, resp_valid, resp_err, sd_oe, sd_out});
        end
        checks++;
        if (resp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", resp_rdata); end
        rst = 1'b0;
        @(negedge clk);
        issue(2'b00, '0);
        push_txn(2'b00, '0, '0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL reset_op T%0d: got %b want %b", i + 1, obs, e.v); end
            if (i == 0) req_valid = 1'b0;
        end
        checks++;
        if (m_reset !== 1'b1) begin failures++; $display("FAIL reset_slave_state: got %b want 1", m_reset); end
    endtask

    task automatic test_write(input logic [DL-1:0] wd);
        exp_t e;
        logic [5:0] obs;
        issue(2'b01, wd);
        push_txn(2'b01, wd, '0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL write T%0d: got %b want %b", i + 1, obs, e.v); end
            if (!e.v[5]) begin
                req_valid = 1'($urandom); req_op = 2'($urandom); req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
        checks++;
        if (m_bit_out !== wd) begin failures++; $display("FAIL write_slave_bits: got %h want %h", m_bit_out, wd); end
    endtask

    task automatic test_read(input logic [DL-1:0] exp_rd);
        exp_t e;
        logic [5:0] obs;
        issue(2'b10, 8'($urandom));
        push_txn(2'b10, '0, exp_rd);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL read T%0d: got %b want %b", i + 1, obs, e.v); end
            if (e.chk) begin
                checks++;
                if (resp_rdata !== e.rdata) begin failures++; $display("FAIL read_rdata: got %h want %h", resp_rdata, e.rdata); end
            end
            if (!e.v[5]) begin
                req_valid = 1'($urandom); req_op = 2'($urandom); req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [5:0] obs;
        issue(2'b01, 8'hA5);
        push_txn(2'b01, 8'hA5, '0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL b2b T%0d: got %b want %b", i + 1, obs, e.v); end
            if (e.chk) begin
                checks++;
                if (resp_rdata !== e.rdata) begin failures++; $display("FAIL b2b_rdata: got %h want %h", resp_rdata, e.rdata); end
            end
            if (i == 0) begin
                req_op = 2'b10; req_wdata = 8'($urandom);
                push_txn(2'b10, '0, 8'hA5);
            end
            if (i == 25) req_valid = 1'b0;
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        logic [5:0] obs;
        issue(2'b11, 8'($urandom));
        push_txn(2'b11, '0, '0);
        push_idle(1);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL reserved T%0d: got %b want %b", i + 1, obs, e.v); end
            if (i == 0) req_valid = 1'b0;
            if (i == 1) begin issue(2'b00, '0); push_txn(2'b00, '0, '0); end
            if (i == 2) req_valid = 1'b0;
        end
        checks++;
        if (m_reset !== 1'b1) begin failures++; $display("FAIL reserved_then_reset: got %b want 1", m_reset); end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [5:0] obs;
        issue(2'b01, 8'hC3);
        push_txn(2'b01, 8'hC3, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL abort_pre T%0d: got %b want %b", i + 1, obs, e.v); end
            if (i == 0) req_valid = 1'b0;
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, sd_oe, sd_out} !== 5'b10010) begin
            failures++; $display("FAIL abort_state: got %b want 10010", {req_ready, resp_valid, resp_err, sd_oe, sd_out});
        end
        checks++;
        if (resp_rdata !== 8'h00) begin failures++; $display("FAIL abort_rdata: got %h want 00", resp_rdata); end
        rst = 1'b0;
        push_idle(3);
        push_txn(2'b00, '0, '0);
        push_txn(2'b01, 8'h3C, '0);
        push_txn(2'b10, '0, 8'h3C);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            obs = {req_ready, resp_valid, e.v[4] ? resp_err : 1'b0, sd_oe, e.v[2] ? sd_out : 1'b0, sd_oe & s_oe};
            checks++;
            if (obs !== e.v) begin failures++; $display("FAIL recover idx%0d: got %b want %b", i, obs, e.v); end
            if (e.chk) begin
                checks++;
                if (resp_rdata !== e.rdata) begin failures++; $display("FAIL recover_rdata: got %h want %h", resp_rdata, e.rdata); end
            end
            if (i == 2)  issue(2'b00, '0);
            if (i == 3)  begin req_op = 2'b01; req_wdata = 8'h3C; end
            if (i == 11) begin req_op = 2'b10; req_wdata = 8'($urandom); end
            if (i == 36) req_valid = 1'b0;
        end
        checks++;
        if (m_bit_out !== 8'h3C) begin failures++; $display("FAIL recover_slave_bits: got %h want 3c", m_bit_out); end
    endtask

    initial begin
        test_reset();
        test_write(8'h48);
        test_read(8'h48);
        test_back_to_back();
        test_reserved();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
